// File: rtl/cache_ctrl_fsm.sv
// Sequencer between a CPU load/store port, a 2-way cache array and a block memory bus.
// Define CACHE_CTRL_STATS_EN to add the hit_cnt/miss_cnt outputs.
module cache_ctrl_fsm #(
   parameter  int OFFSET_WIDTH = 3,
   parameter  int INDEX_WIDTH  = 6,
   localparam int TAG_WIDTH    = 30 - OFFSET_WIDTH - INDEX_WIDTH,
   localparam int BLK_W        = 32 << OFFSET_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cpu_req,
   input  logic                    cpu_we,
   input  logic [3:0]              cpu_byte_en,
   input  logic [31:0]             cpu_addr,
   input  logic [31:0]             cpu_wdata,
   output logic [31:0]             cpu_rdata,
   output logic                    cpu_ready,
   output logic                    cache_enable,
   output logic                    cache_cmp,
   output logic                    cache_write,
   output logic                    cache_valid_in,
   output logic [3:0]              cache_byte_w_en,
   output logic [TAG_WIDTH-1:0]    cache_tag,
   output logic [INDEX_WIDTH-1:0]  cache_index,
   output logic [OFFSET_WIDTH-1:0] cache_word_sel,
   output logic [31:0]             cache_data_in,
   output logic [BLK_W-1:0]        cache_data_block_in,
   input  logic                    cache_hit,
   input  logic                    cache_dirty,
   input  logic                    cache_valid_out,
   input  logic [TAG_WIDTH-1:0]    cache_tag_out,
   input  logic [31:0]             cache_data_out,
   input  logic [BLK_W-1:0]        cache_data_wb,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [31:0]             mem_addr,
   output logic [BLK_W-1:0]        mem_wdata,
   input  logic [BLK_W-1:0]        mem_rdata,
`ifdef CACHE_CTRL_STATS_EN
   output logic [31:0]             hit_cnt,
   output logic [31:0]             miss_cnt,
`endif
   input  logic                    mem_ack
);

   localparam int LOW_W = OFFSET_WIDTH + 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_VICTIM,
      S_WRITEBACK,
      S_REFILL,
      S_INSTALL
   } state_e;

   state_e                  state_q, state_d;
   logic [TAG_WIDTH-1:0]    tag_q, tag_d;
   logic [INDEX_WIDTH-1:0]  index_q, index_d;
   logic [OFFSET_WIDTH-1:0] word_q, word_d;
   logic                    we_q, we_d;
   logic [3:0]              be_q, be_d;
   logic [31:0]             wdata_q, wdata_d;
   logic [TAG_WIDTH-1:0]    vtag_q, vtag_d;
   logic [BLK_W-1:0]        vblk_q, vblk_d;
   logic [BLK_W-1:0]        rblk_q, rblk_d;

   // Word-aligned accesses only; the byte offset is never needed.
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^cpu_addr[1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         tag_q   <= '0;
         index_q <= '0;
         word_q  <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         vtag_q  <= '0;
         vblk_q  <= '0;
         rblk_q  <= '0;
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
         index_q <= index_d;
         word_q  <= word_d;
         we_q    <= we_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         vtag_q  <= vtag_d;
         vblk_q  <= vblk_d;
         rblk_q  <= rblk_d;
      end
   end

   assign cache_tag      = tag_q;
   assign cache_index    = index_q;
   assign cache_word_sel = word_q;
   assign cache_data_in  = wdata_q;

   always_comb begin
      state_d             = state_q;
      tag_d               = tag_q;
      index_d             = index_q;
      word_d              = word_q;
      we_d                = we_q;
      be_d                = be_q;
      wdata_d             = wdata_q;
      vtag_d              = vtag_q;
      vblk_d              = vblk_q;
      rblk_d              = rblk_q;
      cpu_rdata           = '0;
      cpu_ready           = 1'b0;
      cache_enable        = 1'b0;
      cache_cmp           = 1'b0;
      cache_write         = 1'b0;
      cache_valid_in      = 1'b0;
      cache_byte_w_en     = '0;
      cache_data_block_in = '0;
      mem_req             = 1'b0;
      mem_we              = 1'b0;
      mem_addr            = '0;
      mem_wdata           = '0;
      unique case (state_q)
         S_IDLE: begin
            if (cpu_req) begin
               tag_d   = cpu_addr[31 -: TAG_WIDTH];
               index_d = cpu_addr[LOW_W +: INDEX_WIDTH];
               word_d  = cpu_addr[2 +: OFFSET_WIDTH];
               we_d    = cpu_we;
               be_d    = cpu_byte_en;
               wdata_d = cpu_wdata;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            cache_enable    = 1'b1;
            cache_cmp       = 1'b1;
            cache_write     = we_q;
            cache_byte_w_en = we_q ? be_q : 4'h0;
            if (cache_hit) begin
               cpu_ready = 1'b1;
               cpu_rdata = cache_data_out;
               state_d   = S_IDLE;
            end else begin
               state_d = S_VICTIM;
            end
         end
         S_VICTIM: begin
            cache_enable = 1'b1;
            vtag_d       = cache_tag_out;
            vblk_d       = cache_data_wb;
            state_d      = (cache_valid_out && cache_dirty) ? S_WRITEBACK : S_REFILL;
         end
         S_WRITEBACK: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {vtag_q, index_q, LOW_W'(0)};
            mem_wdata = vblk_q;
            if (mem_ack) state_d = S_REFILL;
         end
         S_REFILL: begin
            mem_req  = 1'b1;
            mem_addr = {tag_q, index_q, LOW_W'(0)};
            if (mem_ack) begin
               rblk_d  = mem_rdata;
               state_d = S_INSTALL;
            end
         end
         S_INSTALL: begin
            cache_enable        = 1'b1;
            cache_write         = 1'b1;
            cache_valid_in      = 1'b1;
            cache_byte_w_en     = 4'hF;
            cache_data_block_in = rblk_q;
            state_d             = S_LOOKUP;
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef CACHE_CTRL_STATS_EN
   // replay_q marks the LOOKUP that follows INSTALL so its hit is not counted.
   logic        replay_q;
   logic [31:0] hit_cnt_q, miss_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         replay_q   <= 1'b0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (state_q == S_INSTALL)   replay_q <= 1'b1;
         else if (state_q == S_IDLE) replay_q <= 1'b0;
         if (state_q == S_LOOKUP && cache_hit && !replay_q) hit_cnt_q <= hit_cnt_q + 32'd1;
         if (state_q == S_LOOKUP && !cache_hit)             miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`endif

endmodule
